id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands and control from ID and decodes the 4-bit ALU control code.
- Applies EX/MEM and MEM/WB operand forwarding, then drives the ALU's src1, src2 and ctrl inputs.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands, decodes the ALU
// control code, and applies EX/MEM and MEM/WB forwarding. Optional macro: ID_EX_FORWARDING_EN.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_W-1:0]     rs1_data_i,
  input  logic [DATA_W-1:0]     rs2_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [1:0]            alu_op_i,
  input  logic [4:0]            funct_i,
  input  logic                  alu_src_i,
  input  logic                  reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  exmem_regwrite_i,
  input  logic                  memwb_regwrite_i,
  input  logic [DATA_W-1:0]     exmem_result_i,
  input  logic [DATA_W-1:0]     memwb_result_i,
  output logic                  ex_valid_o,
  output logic [DATA_W-1:0]     src1_o,
  output logic [DATA_W-1:0]     src2_o,
  output logic [3:0]            alu_ctrl_o,
  output logic [DATA_W-1:0]     store_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_write_o
);

  logic                  r_valid, r_reg_write, r_alu_src;
  logic [3:0]            r_alu_ctrl;
  logic [REG_ADDR_W-1:0] r_rd, r_rs1, r_rs2;
  logic [DATA_W-1:0]     r_rs1_data, r_rs2_data, r_imm;
  logic [3:0]            w_ctrl;
  logic [DATA_W-1:0]     w_fwd_rs1, w_fwd_rs2;

  // funct is {funct7[5], funct7[0], funct3}; I-type arithmetic only looks at funct3
  always_comb begin
    w_ctrl = 4'b1111;
    case (alu_op_i)
      2'b00: w_ctrl = 4'b0010;
      2'b01: w_ctrl = 4'b0110;
      2'b10: begin
        case (funct_i)
          5'b00000: w_ctrl = 4'b0010;
          5'b10000: w_ctrl = 4'b0110;
          5'b00111: w_ctrl = 4'b0000;
          5'b00110: w_ctrl = 4'b0001;
          5'b00010: w_ctrl = 4'b0111;
          5'b01000: w_ctrl = 4'b1100;
          default:  w_ctrl = 4'b1111;
        endcase
      end
      2'b11: begin
        case (funct_i[2:0])
          3'b000:  w_ctrl = 4'b0010;
          3'b111:  w_ctrl = 4'b0000;
          3'b110:  w_ctrl = 4'b0001;
          3'b010:  w_ctrl = 4'b0111;
          default: w_ctrl = 4'b1111;
        endcase
      end
      default: w_ctrl = 4'b1111;
    endcase
  end

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (exmem_regwrite_i && (exmem_rd_i == r_rs1) && (r_rs1 != '0))
      w_fwd_rs1 = exmem_result_i;
    else if (memwb_regwrite_i && (memwb_rd_i == r_rs1) && (r_rs1 != '0))
      w_fwd_rs1 = memwb_result_i;
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (exmem_regwrite_i && (exmem_rd_i == r_rs2) && (r_rs2 != '0))
      w_fwd_rs2 = exmem_result_i;
    else if (memwb_regwrite_i && (memwb_rd_i == r_rs2) && (r_rs2 != '0))
      w_fwd_rs2 = memwb_result_i;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_rd_i, memwb_rd_i, exmem_regwrite_i, memwb_regwrite_i,
                          exmem_result_i, memwb_result_i};
  assign w_fwd_rs1 = r_rs1_data;
  assign w_fwd_rs2 = r_rs2_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
    end else if (flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_ctrl  <= '0;
    end else if (stall_i) begin
`ifdef ID_EX_FORWARDING_EN
      // absorb results retiring from MEM/WB while EX is frozen
      r_rs1_data  <= w_fwd_rs1;
      r_rs2_data  <= w_fwd_rs2;
`endif
    end else begin
      r_valid     <= id_valid_i;
      r_reg_write <= reg_write_i & id_valid_i;
      r_alu_src   <= alu_src_i;
      r_alu_ctrl  <= w_ctrl;
      r_rd        <= rd_addr_i;
      r_rs1       <= rs1_addr_i;
      r_rs2       <= rs2_addr_i;
      r_rs1_data  <= rs1_data_i;
      r_rs2_data  <= rs2_data_i;
      r_imm       <= imm_i;
    end
  end

  assign ex_valid_o   = r_valid;
  assign reg_write_o  = r_reg_write & r_valid;
  assign alu_ctrl_o   = r_alu_ctrl;
  assign rd_addr_o    = r_rd;
  assign src1_o       = w_fwd_rs1;
  assign src2_o       = r_alu_src ? r_imm : w_fwd_rs2;
  assign store_data_o = w_fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode table plus hand sequences for forwarding, stall, flush, reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush, alu_src, reg_write;
  logic        exmem_rw, memwb_rw;
  logic [31:0] rs1_data, rs2_data, imm, exmem_res, memwb_res;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd, funct;
  logic [1:0]  alu_op;
  logic        ex_valid, rw_o;
  logic [31:0] src1, src2, store;
  logic [3:0]  ctrl;
  logic [4:0]  rd_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .stall_i(stall), .flush_i(flush),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
    .alu_op_i(alu_op), .funct_i(funct), .alu_src_i(alu_src), .reg_write_i(reg_write),
    .exmem_rd_i(exmem_rd), .memwb_rd_i(memwb_rd),
    .exmem_regwrite_i(exmem_rw), .memwb_regwrite_i(memwb_rw),
    .exmem_result_i(exmem_res), .memwb_result_i(memwb_res),
    .ex_valid_o(ex_valid), .src1_o(src1), .src2_o(src2), .alu_ctrl_o(ctrl),
    .store_data_o(store), .rd_addr_o(rd_o), .reg_write_o(rw_o)
  );

  typedef struct {
    logic        vld, rw, asrc;
    logic [1:0]  op;
    logic [4:0]  fn, rd;
    logic [31:0] d1, d2, im;
    logic [3:0]  e_ctrl;
    logic [31:0] e_src2;
    logic        e_vld, e_rw;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic vld, logic rw, logic asrc, logic [1:0] op, logic [4:0] fn,
                              logic [4:0] rd, logic [31:0] d1, logic [31:0] d2, logic [31:0] im,
                              logic [3:0] e_ctrl, logic [31:0] e_src2, logic e_vld, logic e_rw);
    vec_t v;
    v.vld = vld; v.rw = rw; v.asrc = asrc; v.op = op; v.fn = fn; v.rd = rd;
    v.d1 = d1; v.d2 = d2; v.im = im;
    v.e_ctrl = e_ctrl; v.e_src2 = e_src2; v.e_vld = e_vld; v.e_rw = e_rw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_id(input logic vld, input logic rw, input logic asrc, input logic [1:0] op,
                          input logic [4:0] fn, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] im);
    id_valid = vld; reg_write = rw; alu_src = asrc; alu_op = op; funct = fn;
    rs1_addr = a1; rs2_addr = a2; rd_addr = rd; rs1_data = d1; rs2_data = d2; imm = im;
  endtask

  task automatic clr_fwd();
    exmem_rw = 1'b0; memwb_rw = 1'b0; exmem_rd = '0; memwb_rd = '0;
    exmem_res = '0; memwb_res = '0;
  endtask

  logic [31:0] exp_v;

  initial begin
    tbl[0]  = mk(1, 1, 0, 2'b10, 5'b10000, 5'd7,  32'd9,   32'd4,    32'h0,  4'b0110, 32'd4,   1, 1);
    tbl[1]  = mk(1, 1, 0, 2'b10, 5'b01000, 5'd8,  32'd9,   32'd4,    32'h0,  4'b1100, 32'd4,   1, 1);
    tbl[2]  = mk(1, 1, 0, 2'b10, 5'b00101, 5'd9,  32'd9,   32'd4,    32'h0,  4'b1111, 32'd4,   1, 1);
    tbl[3]  = mk(1, 1, 0, 2'b10, 5'b00000, 5'd1,  32'd20,  32'd22,   32'h0,  4'b0010, 32'd22,  1, 1);
    tbl[4]  = mk(1, 1, 0, 2'b10, 5'b00111, 5'd2,  32'd21,  32'd23,   32'h0,  4'b0000, 32'd23,  1, 1);
    tbl[5]  = mk(1, 1, 0, 2'b10, 5'b00110, 5'd3,  32'd1,   32'd2,    32'h0,  4'b0001, 32'd2,   1, 1);
    tbl[6]  = mk(1, 1, 0, 2'b10, 5'b00010, 5'd4,  32'd5,   32'd6,    32'h0,  4'b0111, 32'd6,   1, 1);
    tbl[7]  = mk(1, 0, 1, 2'b00, 5'b10101, 5'd0,  32'd100, 32'h33,   32'h10, 4'b0010, 32'h10,  1, 0);
    tbl[8]  = mk(1, 0, 0, 2'b01, 5'b00000, 5'd11, 32'd7,   32'd7,    32'h5,  4'b0110, 32'd7,   1, 0);
    tbl[9]  = mk(1, 1, 1, 2'b11, 5'b11111, 5'd12, 32'hF0,  32'h1,    32'hFFFF_FFFF, 4'b0000, 32'hFFFF_FFFF, 1, 1);
    tbl[10] = mk(1, 1, 1, 2'b11, 5'b00011, 5'd13, 32'h1,   32'h2,    32'h3,  4'b1111, 32'h3,   1, 1);
    tbl[11] = mk(1, 1, 1, 2'b11, 5'b10010, 5'd14, 32'h8,   32'h9,    32'hA,  4'b0111, 32'hA,   1, 1);
    tbl[12] = mk(0, 1, 0, 2'b00, 5'b00000, 5'd15, 32'h44,  32'h55,   32'h0,  4'b0010, 32'h55,  0, 0);
    tbl[13] = mk(1, 1, 0, 2'b00, 5'b00000, 5'd0,  32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 4'b0010, 32'hDEAD_BEEF, 1, 1);

    // reset with random inputs
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id($urandom, $urandom, $urandom, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), $urandom, $urandom, $urandom);
    exmem_rw = 1'b1; memwb_rw = 1'b1; exmem_rd = 5'($urandom); memwb_rd = 5'($urandom);
    exmem_res = $urandom; memwb_res = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_rw",    32'(rw_o),     32'd0);
    chk("rst_ctrl",  32'(ctrl),     32'd0);
    chk("rst_rd",    32'(rd_o),     32'd0);
    chk("rst_src1",  src1,          32'd0);
    chk("rst_src2",  src2,          32'd0);
    chk("rst_store", store,         32'd0);
    @(negedge clk);
    rst = 1'b0; clr_fwd();

    // decode/operand table; no forwarding active
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_id(tbl[i].vld, tbl[i].rw, tbl[i].asrc, tbl[i].op, tbl[i].fn, 5'd30, 5'd31, tbl[i].rd,
               tbl[i].d1, tbl[i].d2, tbl[i].im);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ctrl", i),  32'(ctrl),     32'(tbl[i].e_ctrl));
      chk($sformatf("v%0d_src1", i),  src1,          tbl[i].d1);
      chk($sformatf("v%0d_src2", i),  src2,          tbl[i].e_src2);
      chk($sformatf("v%0d_store", i), store,         tbl[i].d2);
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d_rw", i),    32'(rw_o),     32'(tbl[i].e_rw));
      chk($sformatf("v%0d_rd", i),    32'(rd_o),     32'(tbl[i].rd));
    end

    // forwarding priority on rs1=3, and a plain rs2 forward on rs2=6
    @(negedge clk);
    drive_id(1, 1, 0, 2'b00, 5'b0, 5'd3, 5'd6, 5'd9, 32'h11, 32'h22, 32'h0);
    @(posedge clk);
    @(negedge clk);
    exmem_rw = 1'b1; exmem_rd = 5'd3; exmem_res = 32'hAA;
    memwb_rw = 1'b1; memwb_rd = 5'd3; memwb_res = 32'hBB;
    #1;
`ifdef ID_EX_FORWARDING_EN
    exp_v = 32'hAA;
`else
    exp_v = 32'h11;
`endif
    chk("fwd_exmem_wins", src1, exp_v);
    exmem_rw = 1'b0; #1;
`ifdef ID_EX_FORWARDING_EN
    exp_v = 32'hBB;
`else
    exp_v = 32'h11;
`endif
    chk("fwd_memwb", src1, exp_v);
    memwb_rw = 1'b0; exmem_rw = 1'b1; exmem_rd = 5'd6; exmem_res = 32'h66; #1;
`ifdef ID_EX_FORWARDING_EN
    exp_v = 32'h66;
`else
    exp_v = 32'h22;
`endif
    chk("fwd_rs2_store", store, exp_v);
    chk("fwd_rs2_src2",  src2,  exp_v);
    chk("fwd_rs1_nomatch", src1, 32'h11);
    clr_fwd();

    // x0 is never forwarded
    drive_id(1, 1, 0, 2'b00, 5'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    exmem_rw = 1'b1; exmem_rd = 5'd0; exmem_res = 32'h55;
    memwb_rw = 1'b1; memwb_rd = 5'd0; memwb_res = 32'h77;
    #1;
    chk("x0_store", store, 32'h0);
    chk("x0_src1",  src1,  32'h0);
    clr_fwd();

    // stall refresh: rs1=5 data 1, MEM/WB retires 7 into r5 during the first stall cycle
    drive_id(1, 1, 0, 2'b00, 5'b0, 5'd5, 5'd0, 5'd2, 32'd1, 32'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    stall = 1'b1;
    drive_id(1, 1, 1, 2'b10, 5'b01000, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 32'h99);
    memwb_rw = 1'b1; memwb_rd = 5'd5; memwb_res = 32'd7;
    @(posedge clk);
    @(negedge clk);
    clr_fwd();
    @(posedge clk); #1;
`ifdef ID_EX_FORWARDING_EN
    exp_v = 32'd7;
`else
    exp_v = 32'd1;
`endif
    chk("stall_refresh_src1", src1, exp_v);
    chk("stall_hold_ctrl", 32'(ctrl), 32'b0010);
    chk("stall_hold_rd",   32'(rd_o), 32'd2);
    chk("stall_hold_src2", src2, 32'd0);

    // flush beats stall
    @(negedge clk);
    flush = 1'b1; stall = 1'b1;
    drive_id(1, 1, 0, 2'b10, 5'b01000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0);
    @(posedge clk); #1;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw",    32'(rw_o),     32'd0);
    chk("flush_ctrl",  32'(ctrl),     32'd0);

    // reload, then reset while stalled
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    chk("reload_ctrl", 32'(ctrl), 32'b1100);
    @(negedge clk);
    stall = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_stall_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall_ctrl",  32'(ctrl),     32'd0);
    chk("rst_stall_rd",    32'(rd_o),     32'd0);
    chk("rst_stall_src1",  src1,          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
